// File: rtl/gen_row_sequencer.sv
// gen_row_sequencer: steps through the rows of one Game-of-Life generation and
// hands each row, plus its two neighbour rows, to line_buffer. It counts the
// result rows written back, swaps the read/write BRAM banks between
// generations, and runs either a fixed number of generations or free-runs.
module gen_row_sequencer #(
    parameter int unsigned ROWS  = 720,
    parameter int unsigned ROW_W = $clog2(ROWS),
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [GEN_W-1:0] gen_count,
    input  logic             wrap_mode,
    input  logic             stop,
    input  logic             pause,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [ROW_W-1:0] row_cur,
    output logic [ROW_W-1:0] row_prev,
    output logic [ROW_W-1:0] row_next,
    output logic             edge_top,
    output logic             edge_bot,
    input  logic             wb_pulse,
    output logic             rd_bank,
    output logic [GEN_W-1:0] gen_done,
    output logic             busy,
    output logic             done,
    output logic             err_overrun
);

    localparam int unsigned      CNT_W    = ROW_W + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        SWAP   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_cur_q, row_prev_q, row_next_q;
    logic             edge_top_q, edge_bot_q;
    logic             wrap_q;
    logic [GEN_W-1:0] gen_count_q, gen_done_q;
    logic [CNT_W-1:0] wb_cnt_q;
    logic             rd_bank_q, err_q;

    logic             hs;
    logic             row_ld;
    logic             nb_wrap;
    logic [ROW_W-1:0] row_d, prev_d, next_d;
    logic             top_d, bot_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                if (hs && (row_cur_q == LAST_ROW)) state_d = DRAIN;
            end
            DRAIN: begin
                if ((wb_cnt_q == FULL_CNT) || ((wb_cnt_q == LAST_CNT) && wb_pulse))
                    state_d = SWAP;
            end
            SWAP: begin
                if (stop || ((gen_count_q != '0) && ((gen_done_q + GEN_W'(1)) == gen_count_q)))
                    state_d = FINISH;
                else
                    state_d = ISSUE;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; valid is gated by pause so a stall can be imposed upstream
    always_comb begin
        row_valid = (state_q == ISSUE) && !pause;
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
        hs        = row_valid && row_ready;
    end

    // Row index to load next, and the boundary mode its neighbours use
    always_comb begin
        row_d   = row_cur_q;
        nb_wrap = wrap_q;
        row_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    nb_wrap = wrap_mode;
                    row_ld  = 1'b1;
                end
            end
            ISSUE: begin
                if (hs && (row_cur_q != LAST_ROW)) begin
                    row_d  = row_cur_q + ROW_W'(1);
                    row_ld = 1'b1;
                end
            end
            SWAP: begin
                row_d  = '0;
                row_ld = 1'b1;
            end
            default: begin
                row_ld = 1'b0;
            end
        endcase
    end

    // Neighbour rows for the row being loaded; dead edges clamp and flag instead of wrapping
    always_comb begin
        prev_d = row_d - ROW_W'(1);
        top_d  = 1'b0;
        next_d = row_d + ROW_W'(1);
        bot_d  = 1'b0;
        if (row_d == '0) begin
            prev_d = nb_wrap ? LAST_ROW : '0;
            top_d  = !nb_wrap;
        end
        if (row_d == LAST_ROW) begin
            next_d = nb_wrap ? '0 : LAST_ROW;
            bot_d  = !nb_wrap;
        end
    end

    // Row/neighbour registers, run configuration, write-back counter and bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cur_q   <= '0;
            row_prev_q  <= '0;
            row_next_q  <= ROW_W'(1);
            edge_top_q  <= 1'b1;
            edge_bot_q  <= 1'b0;
            wrap_q      <= 1'b0;
            gen_count_q <= '0;
            gen_done_q  <= '0;
            wb_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (row_ld) begin
                row_cur_q  <= row_d;
                row_prev_q <= prev_d;
                row_next_q <= next_d;
                edge_top_q <= top_d;
                edge_bot_q <= bot_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        wrap_q      <= wrap_mode;
                        gen_count_q <= gen_count;
                        gen_done_q  <= '0;
                        wb_cnt_q    <= '0;
                        err_q       <= 1'b0;
                    end
                end
                ISSUE, DRAIN: begin
                    if (wb_pulse) begin
                        if (wb_cnt_q == FULL_CNT)
                            err_q <= 1'b1;
                        else
                            wb_cnt_q <= wb_cnt_q + CNT_W'(1);
                    end
                end
                SWAP: begin
                    rd_bank_q  <= !rd_bank_q;
                    gen_done_q <= gen_done_q + GEN_W'(1);
                    wb_cnt_q   <= '0;
                end
                default: begin
                    wb_cnt_q <= wb_cnt_q;
                end
            endcase
        end
    end

    assign row_cur     = row_cur_q;
    assign row_prev    = row_prev_q;
    assign row_next    = row_next_q;
    assign edge_top    = edge_top_q;
    assign edge_bot    = edge_bot_q;
    assign rd_bank     = rd_bank_q;
    assign gen_done    = gen_done_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_gen_row_sequencer.sv
// Bench for gen_row_sequencer with an 8-row frame: a scoreboard of expected
// row requests, a write-back generator, and one task per scenario.
module tb_gen_row_sequencer;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned GEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [GEN_W-1:0] gen_count;
    logic             wrap_mode;
    logic             stop;
    logic             pause;
    logic             row_valid;
    logic             row_ready;
    logic [ROW_W-1:0] row_cur, row_prev, row_next;
    logic             edge_top, edge_bot;
    logic             wb_pulse;
    logic             wb_auto, wb_manual;
    logic             rd_bank;
    logic [GEN_W-1:0] gen_done;
    logic             busy, done, err_overrun;

    typedef struct packed {
        logic [ROW_W-1:0] cur;
        logic [ROW_W-1:0] prev;
        logic [ROW_W-1:0] next;
        logic             top;
        logic             bot;
    } row_exp_t;

    row_exp_t         exp_q[$];
    row_exp_t         mon_e;
    int               checks = 0;
    int               errors = 0;
    int               done_cnt = 0;
    bit               wb_auto_en = 1'b1;
    logic [2:0]       sched = '0;
    logic             mon_hs;
    logic             stall_seen = 1'b0;
    logic [3*ROW_W-1:0] stall_rows;

    assign wb_pulse = wb_auto | wb_manual;

    gen_row_sequencer #(.ROWS(ROWS), .GEN_W(GEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .gen_count(gen_count),
        .wrap_mode(wrap_mode), .stop(stop), .pause(pause),
        .row_valid(row_valid), .row_ready(row_ready),
        .row_cur(row_cur), .row_prev(row_prev), .row_next(row_next),
        .edge_top(edge_top), .edge_bot(edge_bot), .wb_pulse(wb_pulse),
        .rd_bank(rd_bank), .gen_done(gen_done), .busy(busy), .done(done),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Watchdog so a hung handshake can never stall the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: scoreboard pop on handshake, stall stability, pause gating, write-back generator
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sched      = '0;
                wb_auto    = 1'b0;
                stall_seen = 1'b0;
            end else begin
                mon_hs = row_valid & row_ready;
                if (stall_seen) begin
                    checks++;
                    if ({row_cur, row_prev, row_next} !== stall_rows) begin
                        errors++;
                        $display("FAIL row_stable: rows=%h required %h", {row_cur, row_prev, row_next}, stall_rows);
                    end
                end
                if (pause && busy) begin
                    checks++;
                    if (row_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL pause_valid: row_valid=%b required 0", row_valid);
                    end
                end
                if (mon_hs) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_row: row_cur=%0d with no row expected", row_cur);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if ({row_cur, row_prev, row_next, edge_top, edge_bot} !== mon_e) begin
                            errors++;
                            $display("FAIL row_req: cur/prev/next/top/bot=%0d/%0d/%0d/%b/%b required %0d/%0d/%0d/%b/%b",
                                     row_cur, row_prev, row_next, edge_top, edge_bot,
                                     mon_e.cur, mon_e.prev, mon_e.next, mon_e.top, mon_e.bot);
                        end
                    end
                end
                if (done) done_cnt++;
                stall_seen = row_valid & ~row_ready;
                stall_rows = {row_cur, row_prev, row_next};
                wb_auto    = sched[2];
                sched      = {sched[1:0], mon_hs & wb_auto_en};
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic push_frame(input bit wrap);
        row_exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.cur  = ROW_W'(r);
            e.prev = (r == 0) ? (wrap ? ROW_W'(ROWS - 1) : ROW_W'(0)) : ROW_W'(r - 1);
            e.next = (r == ROWS - 1) ? (wrap ? ROW_W'(0) : ROW_W'(ROWS - 1)) : ROW_W'(r + 1);
            e.top  = (r == 0) && !wrap;
            e.bot  = (r == ROWS - 1) && !wrap;
            exp_q.push_back(e);
        end
    endtask

    task automatic launch(input int gens, input bit wrap);
        start     = 1'b1;
        gen_count = GEN_W'(gens);
        wrap_mode = wrap;
        tick;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < max_cycles) begin
            tick;
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_gen(input int target, input int max_cycles, output bit seen);
        int n = 0;
        seen = (gen_done == GEN_W'(target));
        while (!seen && n < max_cycles) begin
            tick;
            n++;
            if (gen_done == GEN_W'(target)) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid: got %b required 0", row_valid); end
        checks++; if (row_cur !== 3'd0) begin errors++; $display("FAIL reset_row_cur: got %0d required 0", row_cur); end
        checks++; if (row_prev !== 3'd0) begin errors++; $display("FAIL reset_row_prev: got %0d required 0", row_prev); end
        checks++; if (row_next !== 3'd1) begin errors++; $display("FAIL reset_row_next: got %0d required 1", row_next); end
        checks++; if ({edge_top, edge_bot} !== 2'b10) begin errors++; $display("FAIL reset_edges: got %b%b required 10", edge_top, edge_bot); end
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank: got %b required 0", rd_bank); end
        checks++; if (gen_done !== 16'd0) begin errors++; $display("FAIL reset_gen_done: got %0d required 0", gen_done); end
        checks++; if ({busy, done, err_overrun} !== 3'b000) begin errors++; $display("FAIL reset_status: busy/done/err=%b%b%b required 000", busy, done, err_overrun); end
    endtask

    task automatic test_basic;
        int cyc; bit seen; int d0;
        d0 = done_cnt;
        push_frame(1'b0);
        launch(1, 1'b0);
        checks++;
        if ({busy, row_valid, row_cur} !== {1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL basic_first_row: busy/valid/row=%b/%b/%0d required 1/1/0", busy, row_valid, row_cur);
        end
        wait_done(100, cyc, seen);
        checks++; if (!seen || (cyc + 1) != 13) begin errors++; $display("FAIL basic_latency: done seen=%b at cycle %0d required 13", seen, cyc + 1); end
        checks++; if (gen_done !== 16'd1) begin errors++; $display("FAIL basic_gen_done: got %0d required 1", gen_done); end
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL basic_rd_bank: got %b required 1", rd_bank); end
        tick;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_idle: busy/done=%b%b required 00", busy, done); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_rows_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        int k; int toggles; logic last; bit seen;
        do_reset;
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL wrap_bank_start: got %b required 0", rd_bank); end
        for (int g = 0; g < 3; g++) push_frame(1'b1);
        launch(3, 1'b1);
        k = 1; toggles = 0; last = rd_bank; seen = 1'b0;
        while (!seen && k < 200) begin
            tick;
            k++;
            if (rd_bank !== last) toggles++;
            last = rd_bank;
            if (done) seen = 1'b1;
        end
        checks++; if (!seen || k != 37) begin errors++; $display("FAIL wrap_latency: done seen=%b at cycle %0d required 37", seen, k); end
        checks++; if (toggles != 3) begin errors++; $display("FAIL wrap_bank_toggles: got %0d required 3", toggles); end
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL wrap_rd_bank: got %b required 1", rd_bank); end
        checks++; if (gen_done !== 16'd3) begin errors++; $display("FAIL wrap_gen_done: got %0d required 3", gen_done); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_rows_left: got %0d required 0", exp_q.size()); end
        tick;
    endtask

    task automatic test_handshake;
        int i; bit seen;
        push_frame(1'b0);
        launch(1, 1'b0);
        i = 0; seen = 1'b0;
        while (!seen && i < 200) begin
            row_ready = i[0];
            pause     = (i >= 5) && (i < 9);
            tick;
            i++;
            if (done) seen = 1'b1;
        end
        row_ready = 1'b1;
        pause     = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL hs_done: done not seen within %0d cycles", i); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL hs_rows_left: got %0d required 0", exp_q.size()); end
        checks++; if (gen_done !== 16'd1) begin errors++; $display("FAIL hs_gen_done: got %0d required 1", gen_done); end
        tick;
    endtask

    task automatic test_stop_pulse;
        int cyc; bit seen; int d0;
        d0 = done_cnt;
        for (int g = 0; g < 3; g++) push_frame(1'b0);
        launch(0, 1'b0);
        wait_gen(1, 100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL stop_pulse_gen1: gen_done=%0d required 1", gen_done); end
        tick; tick; tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        wait_gen(2, 100, seen);
        checks++; if (!seen || busy !== 1'b1) begin errors++; $display("FAIL stop_pulse_ignored: gen_done=%0d busy=%b required 2/1", gen_done, busy); end
        stop = 1'b1;
        wait_done(100, cyc, seen);
        stop = 1'b0;
        checks++; if (!seen || gen_done !== 16'd3) begin errors++; $display("FAIL stop_pulse_end: done=%b gen_done=%0d required 1/3", seen, gen_done); end
        tick;
        checks++; if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL stop_pulse_count: dones=%0d rows_left=%0d required 1/0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_stop_held;
        int cyc; bit seen;
        for (int g = 0; g < 2; g++) push_frame(1'b1);
        launch(0, 1'b1);
        wait_gen(1, 100, seen);
        stop = 1'b1;
        wait_done(100, cyc, seen);
        stop = 1'b0;
        checks++; if (!seen || gen_done !== 16'd2) begin errors++; $display("FAIL stop_held: done=%b gen_done=%0d required 1/2", seen, gen_done); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stop_held_rows_left: got %0d required 0", exp_q.size()); end
        tick;
    endtask

    task automatic test_overrun_busy;
        int cyc; bit seen;
        wb_auto_en = 1'b0;
        push_frame(1'b0);
        launch(1, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            row_ready = (j != 8);
            wb_manual = (j <= 8) || (j == 10);
            if (j == 10) begin
                checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b required 0", err_overrun); end
            end
            tick;
        end
        wb_manual = 1'b0;
        row_ready = 1'b1;
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b required 1", err_overrun); end
        wait_done(50, cyc, seen);
        tick;
        checks++; if (!seen || err_overrun !== 1'b1 || gen_done !== 16'd1) begin
            errors++; $display("FAIL overrun_sticky: done=%b err=%b gen_done=%0d required 1/1/1", seen, err_overrun, gen_done);
        end
        wb_auto_en = 1'b1;
        for (int g = 0; g < 2; g++) push_frame(1'b1);
        launch(2, 1'b1);
        checks++; if (err_overrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL overrun_clear: err=%b busy=%b required 0/1", err_overrun, busy); end
        tick; tick;
        launch(5, 1'b0);
        wait_done(100, cyc, seen);
        checks++; if (!seen || gen_done !== 16'd2) begin errors++; $display("FAIL start_busy_ignored: done=%b gen_done=%0d required 1/2", seen, gen_done); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL start_busy_rows_left: got %0d required 0", exp_q.size()); end
        tick;
    endtask

    task automatic test_async_reset;
        int n; int cyc; bit seen;
        for (int g = 0; g < 2; g++) push_frame(1'b0);
        launch(2, 1'b0);
        n = 0;
        while (row_cur != 3'd5 && n < 50) begin tick; n++; end
        checks++; if (row_cur !== 3'd5) begin errors++; $display("FAIL rst_reach_row5: row_cur=%0d required 5", row_cur); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({row_valid, row_cur, row_prev, row_next, edge_top, edge_bot, rd_bank, busy, done, err_overrun} !==
            {1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0} || gen_done !== 16'd0) begin
            errors++; $display("FAIL rst_async: valid/cur/prev/next/top/bot/bank/busy/done/err=%b/%0d/%0d/%0d/%b/%b/%b/%b/%b/%b gen=%0d required reset values",
                               row_valid, row_cur, row_prev, row_next, edge_top, edge_bot, rd_bank, busy, done, err_overrun, gen_done);
        end
        exp_q.delete();
        tick; tick;
        rst = 1'b0;
        tick; tick; tick;
        push_frame(1'b0);
        launch(1, 1'b0);
        checks++; if ({row_valid, row_cur, rd_bank} !== {1'b1, 3'd0, 1'b0}) begin
            errors++; $display("FAIL rst_restart: valid/row/bank=%b/%0d/%b required 1/0/0", row_valid, row_cur, rd_bank);
        end
        wait_done(100, cyc, seen);
        checks++; if (!seen || gen_done !== 16'd1 || rd_bank !== 1'b1) begin
            errors++; $display("FAIL rst_rerun: done=%b gen_done=%0d bank=%b required 1/1/1", seen, gen_done, rd_bank);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_rows_left: got %0d required 0", exp_q.size()); end
        tick;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gen_count = '0; wrap_mode = 1'b0;
        stop = 1'b0; pause = 1'b0; row_ready = 1'b1; wb_manual = 1'b0; wb_auto = 1'b0;
        test_reset;
        test_basic;
        test_wrap;
        test_handshake;
        test_stop_pulse;
        test_stop_held;
        test_overrun_busy;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_row_sequencer.md
# gen_row_sequencer

Parametrised generation sequencer for the Game-of-Life datapath. It replaces the fixed 720-row, single-pass row iterator in the top level. It issues row indices and their neighbour indices to `line_buffer` under a valid/ready handshake and counts write-backs from `parallel_next_state`. It ping-pongs the read/write BRAM banks between generations and runs N generations, or free-runs, with toroidal or dead-edge boundaries.

## Interface
- `ROWS`, 720: rows per frame, ≥ 3.
- `ROW_W`, `$clog2(ROWS)`: row index width.
- `GEN_W`, 16: generation counter width.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE.
- `gen_count`  in  GEN_W  generations to run, sampled on accepted `start`; 0 = free-run until `stop`.
- `wrap_mode`  in  1  1 = toroidal, 0 = dead edges; sampled on accepted `start`.
- `stop`  in  1  level; finish current generation, then end run.
- `pause`  in  1  level; holds `row_valid` low while in ISSUE.
- `row_valid`  out  1  row request valid.
- `row_ready`  in  1  `line_buffer` accepts request.
- `row_cur`  out  ROW_W  row being computed.
- `row_prev`, `row_next`  out  ROW_W  neighbour rows to fetch.
- `edge_top`, `edge_bot`  out  1  neighbour is outside the frame; `line_buffer` substitutes zeros (dead-edge only).
- `wb_pulse`  in  1  one result row written by `parallel_next_state`.
- `rd_bank`  out  1  BRAM bank read this generation; write bank is `~rd_bank`.
- `gen_done`  out  GEN_W  generations completed in this run.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of run.
- `err_overrun`  out  1  sticky; a write-back arrived with the counter already at `ROWS`.

## Operation
- States: IDLE, ISSUE, DRAIN, SWAP, FINISH.
- IDLE:
  - `start` latches `gen_count` and `wrap_mode`.
  - Clears `gen_done`, the issue counter, the write-back counter and `err_overrun`.
  - Goes to ISSUE.
- ISSUE:
  - `row_valid = ~pause`.
  - Handshake is `row_valid & row_ready`. On handshake `row_cur` increments.
  - Handshake at `row_cur == ROWS-1` goes to DRAIN; `row_cur` stays at `ROWS-1`.
  - Outputs hold stable while valid and not ready.
  - `pause` may only drop `row_valid` when no handshake occurs in that cycle. This is inherent: ready is sampled with valid.
- Neighbours:
  - `row_prev = row_cur-1`; at row 0 it is `ROWS-1` if wrap, else 0 with `edge_top=1`.
  - `row_next = row_cur+1`; at `ROWS-1` it is 0 if wrap, else `ROWS-1` with `edge_bot=1`.
  - `edge_*` are always 0 in wrap mode.
  - Neighbour outputs are registered alongside `row_cur`, with no combinational path from `row_ready`.
- Write-back counter (ROW_W+1 bits):
  - Increments on `wb_pulse` in ISSUE or DRAIN.
  - A pulse while the counter is already `ROWS` sets `err_overrun` and does not increment.
  - Pulses in other states are ignored.
- DRAIN:
  - Goes to SWAP when the counter equals `ROWS`, or when it equals `ROWS-1` and `wb_pulse` is high in the same cycle.
- SWAP (one cycle):
  - Toggles `rd_bank`, increments `gen_done`, clears both counters, sets `row_cur=0`.
  - Goes to FINISH if `stop`, or if `gen_count≠0` and `gen_done+1 == gen_count`.
  - Otherwise goes to ISSUE.
- FINISH: `done=1` for one cycle, then IDLE.
- `stop` has no effect in IDLE, and is not latched; it is sampled in SWAP only.
- `gen_done` wraps at `2^GEN_W` in free-run.
- `rd_bank` persists across runs; it is not cleared in IDLE. The next run reads the last written bank.
- `rst` mid-run: all state returns to reset values immediately. Write-backs in flight are ignored.

## Timing
- Reset values: state IDLE, `row_valid=0`, `row_cur=0`, `row_prev=0`, `row_next=1`, `edge_top=1`, `edge_bot=0`, `rd_bank=0`, `gen_done=0`, `busy=0`, `done=0`, `err_overrun=0`.
- `start` at cycle t gives `busy` and `row_valid` (row 0) at t+1.
- With `row_ready` held high, rows issue at one per cycle; the last row is accepted at t+ROWS.
- The last `wb_pulse` at cycle w gives SWAP at w+1 (the same-cycle rule above). `rd_bank` flips at w+2.
- The next generation's row 0 is valid at w+2, or `done` pulses at w+2 and `busy` drops at w+3.
- Generation overhead beyond issue and write-back: 1 cycle (SWAP).

## Test plan
- ROWS=8, wrap=0, gen_count=1, ready=1, `wb_pulse` 3 cycles after each issue:
  - rows 0..7 issue on consecutive cycles.
  - row 0: prev 0, `edge_top=1`; row 7: next 7, `edge_bot=1`.
  - exactly one `done`; `gen_done=1`; `rd_bank=1`.
- ROWS=8, wrap=1, gen_count=3:
  - row 0 prev=7; row 7 next=0; `edge_*` always 0.
  - `rd_bank` goes 0→1→0→1.
  - `done` after the 3rd SWAP; `gen_done=3`.
- `row_ready` toggling 1/0 and `pause` held 4 cycles mid-frame:
  - no row skipped or duplicated.
  - `row_cur` stable while valid and not ready.
  - `row_valid` low throughout the pause.
- gen_count=0 (free-run), `stop` asserted for 1 cycle during generation 2:
  - ignored, because it is not sampled in SWAP.
- gen_count=0 (free-run), `stop` held through generation 2's SWAP:
  - `done` after generation 2; `gen_done=2`.
- Overrun and start-while-busy:
  - inject a 9th `wb_pulse` with ROWS=8 in DRAIN → `err_overrun=1`, sticky until the next accepted `start`.
  - `start` while busy → ignored.
- `rst` pulsed asynchronously mid-ISSUE at row 5:
  - all outputs at reset values immediately.
  - a new `start` issues from row 0 with `rd_bank=0`.
